// File: rtl/fixed_latency_arbiter.sv
// fixed_latency_arbiter: round-robin sharing of one fixed-latency unit with credit-protected per-requester result buffers
module fixed_latency_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DIN_W     = 16,
  parameter int DOUT_W    = 16,
  parameter int LATENCY   = 3,
  parameter int BUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DIN_W-1:0]  din_data,
  input  logic [NUM_REQ-1:0]        din_valid,
  output logic [NUM_REQ-1:0]        din_ready,
  output logic [DIN_W-1:0]          unit_din_data,
  output logic                      unit_din_valid,
  input  logic [DOUT_W-1:0]         unit_dout_data,
  output logic [NUM_REQ*DOUT_W-1:0] dout_data,
  output logic [NUM_REQ-1:0]        dout_valid,
  input  logic [NUM_REQ-1:0]        dout_ready
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_REQ);
  logic [CW-1:0]     credit [NUM_REQ];
  logic [IW-1:0]     rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant, push, pop;
  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]     tag_i [LATENCY];
  logic [PW:0]       wp [NUM_REQ];
  logic [PW:0]       rp [NUM_REQ];
  logic [DOUT_W-1:0] mem [NUM_REQ][BUF_DEPTH];

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  // Round-robin: scan offsets from the far end so the nearest eligible index to rr_ptr wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (!rst && din_valid[wrap(int'(rr_ptr) + k)] && credit[wrap(int'(rr_ptr) + k)] != '0) begin
        grant = '0;
        grant[wrap(int'(rr_ptr) + k)] = 1'b1;
        gidx = wrap(int'(rr_ptr) + k);
      end
  end

  assign din_ready      = grant;
  assign unit_din_valid = |grant;
  assign unit_din_data  = |grant ? din_data[int'(gidx)*DIN_W +: DIN_W] : '0;

  // Pointer advances past the winner so it becomes lowest priority next cycle
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (|grant) rr_ptr <= wrap(int'(gidx) + 1);

  // Tag pipeline mirrors the unit so each result knows its owner
  always_ff @(posedge clk) begin
    tag_v[0] <= rst ? 1'b0 : |grant;
    tag_i[0] <= gidx;
    for (int k = 1; k < LATENCY; k++) begin
      tag_v[k] <= rst ? 1'b0 : tag_v[k-1];
      tag_i[k] <= tag_i[k-1];
    end
  end

  // Buffer status and head data per requester
  always_comb begin
    push = '0;
    pop  = '0;
    dout_valid = '0;
    dout_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dout_valid[i] = wp[i] != rp[i];
      pop[i]  = dout_valid[i] & dout_ready[i];
      push[i] = tag_v[LATENCY-1] && tag_i[LATENCY-1] == IW'(i);
      dout_data[i*DOUT_W +: DOUT_W] = mem[i][rp[i][PW-1:0]];
    end
  end

  // Pointers and credits; credits reserve a slot at grant so pushes never overflow
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (rst) begin
        wp[i]     <= '0;
        rp[i]     <= '0;
        credit[i] <= CW'(BUF_DEPTH);
      end else begin
        wp[i]     <= wp[i] + (PW+1)'(push[i]);
        rp[i]     <= rp[i] + (PW+1)'(pop[i]);
        credit[i] <= credit[i] - CW'(grant[i]) + CW'(pop[i]);
      end

  // Result storage
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (push[i]) mem[i][wp[i][PW-1:0]] <= unit_dout_data;
endmodule

// File: tb/tb_fixed_latency_arbiter.sv
// tb_fixed_latency_arbiter: randomized and directed checks against a queue-based reference model
module tb_fixed_latency_arbiter;
  localparam int N = 4, DW = 16, OW = 16, LAT = 3, BD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*DW-1:0] din_data = '0;
  logic [N-1:0] din_valid = '0, dout_ready = '0;
  logic [N-1:0] din_ready, dout_valid;
  logic [DW-1:0] unit_din_data;
  logic unit_din_valid;
  logic [OW-1:0] unit_dout_data;
  logic [N*OW-1:0] dout_data;
  logic [OW-1:0] upipe [LAT];
  logic [N-1:0] o_ready, o_dv;
  logic o_uv;
  logic [DW-1:0] o_ud;
  logic [N*OW-1:0] o_dd;
  int qv [N][$];
  int qa [N][$];
  int rr = 0, cyc = 0, vecs = 0, errs = 0, cnt;

  fixed_latency_arbiter #(.NUM_REQ(N), .DIN_W(DW), .DOUT_W(OW), .LATENCY(LAT), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .unit_din_data(unit_din_data), .unit_din_valid(unit_din_valid), .unit_dout_data(unit_dout_data),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  // Shared unit model: adds one, LAT cycles from issue edge to result
  always @(posedge clk) begin
    upipe[0] <= unit_din_data + 16'd1;
    for (int k = 1; k < LAT; k++) upipe[k] <= upipe[k-1];
  end
  assign unit_dout_data = upipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] dv, input logic [N*DW-1:0] dd, input logic [N-1:0] dr);
    int g;
    logic [N-1:0] eg, ev;
    @(negedge clk);
    rst = r; din_valid = dv; din_data = dd; dout_ready = dr;
    #1;
    o_ready = din_ready; o_uv = unit_din_valid; o_ud = unit_din_data; o_dv = dout_valid; o_dd = dout_data;
    if (r) begin
      check("ready_in_rst", 64'(o_ready), 64'd0);
      check("uvalid_in_rst", 64'(o_uv), 64'd0);
      for (int i = 0; i < N; i++) begin qv[i].delete(); qa[i].delete(); end
      rr = 0;
    end else begin
      g = -1;
      for (int k = N - 1; k >= 0; k--)
        if (dv[(rr + k) % N] && qv[(rr + k) % N].size() < BD) g = (rr + k) % N;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      check("din_ready", 64'(o_ready), 64'(eg));
      check("unit_valid", 64'(o_uv), 64'(g >= 0));
      if (g >= 0) check("unit_data", 64'(o_ud), 64'(dd[g*DW +: DW]));
      for (int i = 0; i < N; i++) ev[i] = qv[i].size() > 0 && qa[i][0] <= cyc;
      check("dout_valid", 64'(o_dv), 64'(ev));
      for (int i = 0; i < N; i++)
        if (ev[i]) begin
          check("dout_data", 64'(o_dd[i*OW +: OW]), 64'(qv[i][0]));
          if (dr[i]) begin void'(qv[i].pop_front()); void'(qa[i].pop_front()); end
        end
      if (g >= 0) begin
        qv[g].push_back((int'(dd[g*DW +: DW]) + 1) & 'hFFFF);
        qa[g].push_back(cyc + LAT + 1);
        rr = (g + 1) % N;
      end
    end
    cyc++;
  endtask

  initial begin
    repeat (3) step(1'b1, '0, '0, '0);
    // single request: issue in cycle 0, result valid in cycle LAT+1
    step(1'b0, 4'b0010, 64'h0000_0000_0005_0000, '0);
    check("t1_ready", 64'(o_ready), 64'b0010);
    check("t1_uvalid", 64'(o_uv), 64'd1);
    check("t1_udata", 64'(o_ud), 64'h5);
    repeat (3) begin
      step(1'b0, '0, '0, '0);
      check("t1_early", 64'(o_dv), 64'd0);
    end
    step(1'b0, '0, '0, 4'hF);
    check("t1_dvalid", 64'(o_dv), 64'b0010);
    check("t1_ddata", 64'(o_dd[31:16]), 64'h6);
    // all requesters busy: strict rotation
    step(1'b1, '0, '0, '0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'hF, {$urandom, $urandom}, 4'hF);
      check("t2_rotation", 64'(o_ready), 64'(1) << (k % 4));
    end
    // blocked consumer: exactly BD grants, then one grant per pop
    step(1'b1, '0, '0, '0);
    cnt = 0;
    repeat (10) begin
      step(1'b0, 4'b0100, {$urandom, $urandom}, '0);
      cnt += int'(o_ready[2]);
    end
    check("t3_grants", 64'(cnt), 64'd4);
    check("t3_stalled", 64'(o_ready), 64'd0);
    repeat (20) step(1'b0, 4'b0100, {$urandom, $urandom}, 4'b0100);
    // reset with requests in flight: late results must be dropped
    step(1'b1, '0, '0, '0);
    repeat (3) step(1'b0, 4'b0111, {$urandom, $urandom}, '0);
    step(1'b1, '0, '0, '0);
    repeat (6) begin
      step(1'b0, '0, '0, '0);
      check("t6_dvalid", 64'(o_dv), 64'd0);
    end
    cnt = 0;
    repeat (6) begin
      step(1'b0, 4'b0001, {$urandom, $urandom}, '0);
      cnt += int'(o_ready[0]);
    end
    check("t6_credits", 64'(cnt), 64'd4);
    // randomized traffic with occasional reset
    repeat (4000) step(1'($urandom_range(299) == 0), 4'($urandom), {$urandom, $urandom}, 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
